// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one fixed-latency read port between two requesters,
// round-robin issue with one pending slot each, returns routed by an in-order tag FIFO.
module rom_read_arbiter #(
    parameter int RAM_SIZE = 1024,
    parameter int WORD_LEN = 8,
    parameter int RAM_READ_LATENCY = 2,
    localparam int AW = $clog2(RAM_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_readclk,
    input  logic [AW-1:0]       req0_raddr,
    output logic                req0_outclk,
    output logic [WORD_LEN-1:0] req0_out,
    input  logic                req1_readclk,
    input  logic [AW-1:0]       req1_raddr,
    output logic                req1_outclk,
    output logic [WORD_LEN-1:0] req1_out,
    output logic                ram_readclk,
    output logic [AW-1:0]       ram_raddr,
    input  logic                ram_outclk,
    input  logic [WORD_LEN-1:0] ram_out,
    output logic                busy,
    output logic                err
);
    localparam int D  = RAM_READ_LATENCY + 2;
    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D + 1);

    logic          p0_v_q, p0_v_d, p1_v_q, p1_v_d;
    logic [AW-1:0] p0_a_q, p0_a_d, p1_a_q, p1_a_d, ra_q, ra_d;
    logic          last_q, last_d, err_q, err_d, rd_q, rd_d;
    logic [D-1:0]  tag_q, tag_d;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c0, c1, g0, g1, push, pop, empty, head;

    always_comb begin
        c0     = p0_v_q | req0_readclk;
        c1     = p1_v_q | req1_readclk;
        g0     = c0 & (~c1 | last_q);
        g1     = c1 & (~c0 | ~last_q);
        push   = g0 | g1;
        empty  = cnt_q == '0;
        head   = tag_q[rp_q];
        pop    = ram_outclk & ~empty;
        rd_d   = push;
        ra_d   = g1 ? (p1_v_q ? p1_a_q : req1_raddr) : g0 ? (p0_v_q ? p0_a_q : req0_raddr) : ra_q;
        last_d = push ? g1 : last_q;
        // a fresh request is parked when its slot frees up, or when it loses with no slot in use
        p0_v_d = p0_v_q ? (~g0 | req0_readclk) : (req0_readclk & ~g0);
        p1_v_d = p1_v_q ? (~g1 | req1_readclk) : (req1_readclk & ~g1);
        p0_a_d = (req0_readclk & (p0_v_q == g0)) ? req0_raddr : p0_a_q;
        p1_a_d = (req1_readclk & (p1_v_q == g1)) ? req1_raddr : p1_a_q;
        err_d  = err_q | (p0_v_q & ~g0 & req0_readclk) | (p1_v_q & ~g1 & req1_readclk)
               | (ram_outclk & empty);
        tag_d  = tag_q;
        if (push) tag_d[wp_q] = g1;
        wp_d   = push ? ((wp_q == PW'(D - 1)) ? '0 : wp_q + PW'(1)) : wp_q;
        rp_d   = pop ? ((rp_q == PW'(D - 1)) ? '0 : rp_q + PW'(1)) : rp_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_v_q <= 1'b0;
            p1_v_q <= 1'b0;
            p0_a_q <= '0;
            p1_a_q <= '0;
            ra_q   <= '0;
            last_q <= 1'b1;
            err_q  <= 1'b0;
            rd_q   <= 1'b0;
            tag_q  <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
        end else begin
            p0_v_q <= p0_v_d;
            p1_v_q <= p1_v_d;
            p0_a_q <= p0_a_d;
            p1_a_q <= p1_a_d;
            ra_q   <= ra_d;
            last_q <= last_d;
            err_q  <= err_d;
            rd_q   <= rd_d;
            tag_q  <= tag_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ram_readclk = rd_q;
    assign ram_raddr   = ra_q;
    assign req0_outclk = pop & ~head;
    assign req1_outclk = pop & head;
    assign req0_out    = ram_out;
    assign req1_out    = ram_out;
    assign busy        = p0_v_q | p1_v_q | ~empty | rd_q;
    assign err         = err_q;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter: directed bench with latency-2 and latency-3 arbiters sharing stimulus,
// each fed by its own reset-sharing ROM model.
module tb_rom_read_arbiter;
    logic       clk = 1'b0, rst = 1'b1;
    logic       r0c = 1'b0, r1c = 1'b0;
    logic [9:0] r0a = '0, r1a = '0;
    logic       rc2, oc2, q0c2, q1c2, busy2, err2;
    logic       rc3, oc3, q0c3, q1c3, busy3, err3;
    logic [9:0] ra2, ra3;
    logic [7:0] od2, od3, q0d2, q1d2, q0d3, q1d3;
    logic [1:0] v2;
    logic [2:0] v3;
    logic [7:0] d2 [2];
    logic [7:0] d3 [3];
    int         npass = 0, ntot = 0;
    logic [9:0] iq[$], e0[$], e1[$];
    int         ord[$];

    always #10 clk = ~clk;

    function automatic logic [7:0] rom(input logic [9:0] a);
        return (a[7:0] * 8'd3 + 8'd7) ^ a[9:2];
    endfunction

    rom_read_arbiter #(.RAM_SIZE(1024), .WORD_LEN(8), .RAM_READ_LATENCY(2)) u2 (
        .clk(clk), .rst(rst),
        .req0_readclk(r0c), .req0_raddr(r0a), .req0_outclk(q0c2), .req0_out(q0d2),
        .req1_readclk(r1c), .req1_raddr(r1a), .req1_outclk(q1c2), .req1_out(q1d2),
        .ram_readclk(rc2), .ram_raddr(ra2), .ram_outclk(oc2), .ram_out(od2),
        .busy(busy2), .err(err2));

    rom_read_arbiter #(.RAM_SIZE(1024), .WORD_LEN(8), .RAM_READ_LATENCY(3)) u3 (
        .clk(clk), .rst(rst),
        .req0_readclk(r0c), .req0_raddr(r0a), .req0_outclk(q0c3), .req0_out(q0d3),
        .req1_readclk(r1c), .req1_raddr(r1a), .req1_outclk(q1c3), .req1_out(q1d3),
        .ram_readclk(rc3), .ram_raddr(ra3), .ram_outclk(oc3), .ram_out(od3),
        .busy(busy3), .err(err3));

    always @(posedge clk or posedge rst) begin
        if (rst) v2 <= '0;
        else begin
            v2    <= {v2[0], rc2};
            d2[0] <= rom(ra2);
            d2[1] <= d2[0];
        end
    end
    assign oc2 = v2[1];
    assign od2 = d2[1];

    always @(posedge clk or posedge rst) begin
        if (rst) v3 <= '0;
        else begin
            v3    <= {v3[1:0], rc3};
            d3[0] <= rom(ra3);
            d3[1] <= d3[0];
            d3[2] <= d3[1];
        end
    end
    assign oc3 = v3[2];
    assign od3 = d3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        r0c = 1'b0;
        r1c = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0c = 1'b0;
        r1c = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_readclk", rc2, 0);
        chk("rst_raddr", ra2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_err", err2, 0);
        chk("rst_outclk", {q0c2, q1c2}, 0);
        chk("rst_busy_l3", busy3, 0);
        rst = 1'b0;
    endtask

    task automatic sb2();
        logic [9:0] a;
        if (rc2) begin
            chk("issue_expected", 32'(iq.size() > 0), 1);
            if (iq.size() > 0) begin
                a = iq.pop_front();
                chk("issue_addr", ra2, a);
            end
        end
        if (q0c2) begin
            chk("ret0_expected", 32'(e0.size() > 0), 1);
            if (e0.size() > 0) begin
                a = e0.pop_front();
                chk("ret0_data", q0d2, rom(a));
            end
            ord.push_back(0);
        end
        if (q1c2) begin
            chk("ret1_expected", 32'(e1.size() > 0), 1);
            if (e1.size() > 0) begin
                a = e1.pop_front();
                chk("ret1_data", q1d2, rom(a));
            end
            ord.push_back(1);
        end
    endtask

    initial begin
        int code;
        int j;
        bit x0, x1;
        // single uncontended read
        do_reset();
        r0c = 1'b1; r0a = 10'h010;
        cyc();
        chk("t1_readclk", rc2, 1);
        chk("t1_raddr", ra2, 10'h010);
        chk("t1_busy", busy2, 1);
        cyc();
        chk("t1_early", q0c2, 0);
        cyc();
        chk("t1_outclk0", q0c2, 1);
        chk("t1_data0", q0d2, rom(10'h010));
        chk("t1_outclk1", q1c2, 0);
        cyc();
        chk("t1_idle", busy2, 0);
        chk("t1_err", err2, 0);
        // simultaneous first contention: requester 0 first
        do_reset();
        r0c = 1'b1; r0a = 10'h020;
        r1c = 1'b1; r1a = 10'h030;
        cyc();
        chk("t2_raddr_a", ra2, 10'h020);
        cyc();
        chk("t2_readclk_b", rc2, 1);
        chk("t2_raddr_b", ra2, 10'h030);
        cyc();
        chk("t2_out0", {q0c2, q1c2}, 2'b10);
        chk("t2_data0", q0d2, rom(10'h020));
        cyc();
        chk("t2_out1", {q0c2, q1c2}, 2'b01);
        chk("t2_data1", q1d2, rom(10'h030));
        chk("t2_busy_t4", busy2, 1);
        cyc();
        chk("t2_busy_t5", busy2, 0);
        // both streams every 2 cycles: strict 0,1 alternation
        do_reset();
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) begin
                r0c = 1'b1; r0a = 10'h100 + 10'(i / 2);
                r1c = 1'b1; r1a = 10'h200 + 10'(i / 2);
                iq.push_back(r0a); iq.push_back(r1a);
                e0.push_back(r0a); e1.push_back(r1a);
            end
            cyc();
            sb2();
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            sb2();
        end
        chk("t3_all_issued", iq.size(), 0);
        chk("t3_all_ret", e0.size() + e1.size(), 0);
        chk("t3_err", err2, 0);
        chk("t3_idle", busy2, 0);
        // overload: req1 0x42 dropped
        do_reset();
        ord.delete();
        iq = '{10'h050, 10'h040, 10'h051, 10'h041, 10'h052};
        e0 = '{10'h050, 10'h051, 10'h052};
        e1 = '{10'h040, 10'h041};
        r0c = 1'b1; r0a = 10'h050; r1c = 1'b1; r1a = 10'h040;
        cyc(); sb2();
        r0c = 1'b1; r0a = 10'h051; r1c = 1'b1; r1a = 10'h041;
        cyc(); sb2();
        chk("t4_err_t2", err2, 0);
        r0c = 1'b1; r0a = 10'h052; r1c = 1'b1; r1a = 10'h042;
        cyc(); sb2();
        chk("t4_err_t3", err2, 1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            sb2();
        end
        code = 0;
        foreach (ord[k]) code = code | (ord[k] << k);
        chk("t4_ret_count", ord.size(), 5);
        chk("t4_ret_order", code, 5'b01010);
        chk("t4_left", iq.size() + e0.size() + e1.size(), 0);
        chk("t4_err_sticky", err2, 1);
        // async reset with two reads in flight and one pending
        do_reset();
        r0c = 1'b1; r0a = 10'h060; r1c = 1'b1; r1a = 10'h070;
        cyc();
        r0c = 1'b1; r0a = 10'h061;
        cyc();
        chk("t5_busy_pre", busy2, 1);
        rst = 1'b1;
        #1;
        chk("t5_readclk", rc2, 0);
        chk("t5_raddr", ra2, 0);
        chk("t5_busy", busy2, 0);
        chk("t5_outclk", {q0c2, q1c2}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r1c = 1'b1; r1a = 10'h005;
        cyc();
        chk("t5_readclk_after", rc2, 1);
        chk("t5_raddr_after", ra2, 10'h005);
        cyc();
        cyc();
        chk("t5_out", {q0c2, q1c2}, 2'b01);
        chk("t5_data", q1d2, rom(10'h005));
        chk("t5_err", err2, 0);
        // latency 3, interleaved 4-cycle streams over 62 bytes
        do_reset();
        for (int i = 0; i < 136; i++) begin
            j  = i - 4;
            x0 = j >= 0 && j % 4 == 0 && j / 4 < 31;
            x1 = j >= 0 && j % 4 == 2 && j / 4 < 31;
            chk("l3_outclk0", q0c3, x0);
            if (x0) chk("l3_data0", q0d3, rom(10'(j / 4)));
            chk("l3_outclk1", q1c3, x1);
            if (x1) chk("l3_data1", q1d3, rom(10'(31 + j / 4)));
            r0c = i % 4 == 0 && i / 4 < 31; r0a = 10'(i / 4);
            r1c = i % 4 == 2 && i / 4 < 31; r1a = 10'(31 + i / 4);
            cyc();
        end
        chk("l3_err", err3, 0);
        chk("l3_idle", busy3, 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
